// File: rtl/divider16by8_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
// Optional macro DIVIDER_CHECK_EN adds divide-by-zero / quotient-overflow detection on err.
module divider16by8_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   A,
  output logic [N-1:0]   R,
  output logic           err
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [N:0]      rem_q;
  logic [N-1:0]    sh_q;
  logic [N-1:0]    b_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    r_q;

  logic [N:0]      t_d;
  logic [N:0]      rem_d;
  logic [N-1:0]    sh_d;

  // sh_q starts as the low dividend half and fills with quotient bits from the LSB
  always_comb begin
    t_d   = {rem_q[N-1:0], sh_q[N-1]};
    rem_d = t_d;
    sh_d  = {sh_q[N-2:0], 1'b0};
    if (t_d >= {1'b0, b_q}) begin
      rem_d   = t_d - {1'b0, b_q};
      sh_d[0] = 1'b1;
    end
  end

`ifdef DIVIDER_CHECK_EN
  logic err_q;
  logic err_pend_q;
  logic bad_d;

  assign bad_d = (B == '0) || (P[2*N-1:N] >= B);
  assign err   = err_q;
`else
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      sh_q        <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      r_q         <= '0;
`ifdef DIVIDER_CHECK_EN
      err_q       <= 1'b0;
      err_pend_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            b_q        <= B;
            rem_q      <= {1'b0, P[2*N-1:N]};
            sh_q       <= P[N-1:0];
            cnt_q      <= CW'(N);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
`ifdef DIVIDER_CHECK_EN
            err_pend_q <= bad_d;
            err_q      <= 1'b0;
`endif
          end
        end
        CALC: begin
`ifdef DIVIDER_CHECK_EN
          // Bad operands resolve on the first CALC edge without stepping
          if (err_pend_q) begin
            a_q         <= '1;
            r_q         <= '1;
            err_q       <= 1'b1;
            err_pend_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
`endif
            rem_q <= rem_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              a_q         <= sh_d;
              r_q         <= rem_d[N-1:0];
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
`ifdef DIVIDER_CHECK_EN
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign R         = r_q;

endmodule
